// File: rtl/uart_frame_rx_pkg.sv
`default_nettype none
//--------------------------------------------------------------------------
// uart_frame_rx_pkg -- shared states, error codes and sizing helper. Rev 1.0
//--------------------------------------------------------------------------
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_OVR     = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // A single-entry buffer still needs a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
//--------------------------------------------------------------------------
// uart_frame_buf -- payload register file, sync write / async read. Rev 1.0
//--------------------------------------------------------------------------
module uart_frame_buf
  import uart_frame_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
//--------------------------------------------------------------------------
// uart_frame_rx -- sync-hunting framed receiver, checksum-gated drain. Rev 1.0
//--------------------------------------------------------------------------
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int              PW        = ptr_width(MAX_LEN);
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [8:0]      MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TW-1:0]   TC_LAST   = TW'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [TW-1:0] tcnt;
  logic [7:0]    rd_data;
  logic [8:0]    len_m1;
  logic          timed;
  logic          tc_hit;
  logic          wr_en;
  logic          handshake;

  assign len_m1    = {1'b0, len} - 9'd1;
  assign timed     = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  // A byte arriving on the terminal count cycle takes priority over the timeout.
  assign tc_hit    = timed && !rcv && (tcnt == TC_LAST);
  assign wr_en     = (state == ST_PAYLOAD) && rcv;
  assign handshake = out_valid && out_ready;

  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state != ST_HUNT);
  assign out_data  = out_valid ? rd_data : 8'h00;
  assign out_last  = out_valid && (9'(rptr) == len_m1);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (data),
    .rd_addr (rptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      len       <= 8'd0;
      sum       <= 8'd0;
      wptr      <= '0;
      rptr      <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
      err_code  <= ERR_TIMEOUT;
    end else begin
      frame_err <= 1'b0;
      err_code  <= ERR_TIMEOUT;

      if (!timed || rcv) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      case (state)
        ST_HUNT: begin
          if (rcv && (data == SYNC_BYTE)) begin
            state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (rcv) begin
            if ((data == 8'd0) || ({1'b0, data} > MAX_LEN_W)) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= ST_HUNT;
            end else begin
              len   <= data;
              sum   <= data;
              wptr  <= '0;
              state <= ST_PAYLOAD;
            end
          end else if (tc_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_HUNT;
          end
        end

        ST_PAYLOAD: begin
          if (rcv) begin
            sum  <= sum + data;
            wptr <= wptr + PW'(1);
            if (9'(wptr) == len_m1) begin
              state <= ST_CHECK;
            end
          end else if (tc_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_HUNT;
          end
        end

        ST_CHECK: begin
          if (rcv) begin
            if (data == sum) begin
              rptr  <= '0;
              state <= ST_DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= ST_HUNT;
            end
          end else if (tc_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_HUNT;
          end
        end

        ST_DRAIN: begin
          if (rcv) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVR;
          end
          if (handshake) begin
            if (out_last) begin
              state <= ST_HUNT;
            end else begin
              rptr <= rptr + PW'(1);
            end
          end
        end

        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
//--------------------------------------------------------------------------
// tb_uart_frame_rx -- directed plus randomized frame stream against a frame-level model.
//--------------------------------------------------------------------------
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rcv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;
  bit mon_en = 1'b0;

  logic [8:0] exp_q[$];
  logic [1:0] err_q[$];

  always #5 clk = ~clk;

  uart_frame_rx #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAX_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rcv       (rcv),
    .data      (data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sync_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rcv  = 1'b1;
    data = b;
    sync_cyc();
    rcv  = 1'b0;
    data = 8'($urandom);
    repeat (gap) sync_cyc();
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("idle_reached", 32'(done), 32'd1);
    sync_cyc();
  endtask

  task automatic check_queues();
    check_eq("exp_bytes_left", 32'(exp_q.size()), 32'd0);
    check_eq("exp_errs_left", 32'(err_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync_cyc();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);
    sync_cyc();
  endtask

  // Consumer readiness: 0 = hold off, 1 = always ready, otherwise random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else                    out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: every accepted byte and every error pulse must be predicted.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_byte", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e[7:0]));
            check_eq("out_last", 32'(out_last), 32'(e[8]));
          end
        end
        if (frame_err) begin
          if (err_q.size() == 0) begin
            check_eq("unexpected_err", 32'(frame_err), 32'd0);
          end else begin
            check_eq("err_code", 32'(err_code), 32'(err_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  function automatic int rgap();
    return $urandom_range(0, 3);
  endfunction

  initial begin
    int          first;
    logic        busy_prev;
    logic [7:0]  b;
    logic [7:0]  sum;
    int          len;
    int          kind;
    int          ng;
    int          k;

    sync_cyc();
    mon_en = 1'b1;
    do_reset();

    // Good frame, consumer always ready.
    rdy_mode = 1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h69, 0);
    @(negedge clk);
    check_eq("good_valid_latency", 32'(out_valid), 32'd1);
    sync_cyc();
    wait_idle(50);
    check_queues();

    // Bad checksum.
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0);
    err_q.push_back(2'd2);
    send_byte(8'h6A, 0);
    @(negedge clk);
    check_eq("badchk_pulse", 32'(frame_err), 32'd1);
    check_eq("badchk_code", 32'(err_code), 32'd2);
    check_eq("badchk_no_valid", 32'(out_valid), 32'd0);
    sync_cyc();
    wait_idle(20);
    check_queues();

    // Length errors and garbage before a frame.
    send_byte(8'hA5, 0);
    err_q.push_back(2'd1);
    send_byte(8'h00, 0);
    @(negedge clk);
    check_eq("len0_code", 32'(frame_err ? {2'b00, err_code} : 4'hF), 32'd1);
    sync_cyc();
    send_byte(8'hA5, 0);
    err_q.push_back(2'd1);
    send_byte(8'h11, 0);
    @(negedge clk);
    check_eq("len17_code", 32'(frame_err ? {2'b00, err_code} : 4'hF), 32'd1);
    sync_cyc();
    exp_q.push_back({1'b1, 8'h7F});
    send_byte(8'h00, 1); send_byte(8'hFF, 1);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'h80, 0);
    wait_idle(20);
    check_queues();

    // Backpressure with an overrun sync byte during the hold.
    rdy_mode = 0;
    sync_cyc();
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h69, 0);
    @(negedge clk);
    check_eq("hold_valid", 32'(out_valid), 32'd1);
    check_eq("hold_data0", 32'(out_data), 32'h11);
    check_eq("hold_last0", 32'(out_last), 32'd0);
    sync_cyc();
    repeat (10) sync_cyc();
    err_q.push_back(2'd3);
    send_byte(8'hA5, 0);
    @(negedge clk);
    check_eq("ovr_pulse", 32'(frame_err), 32'd1);
    check_eq("ovr_code", 32'(err_code), 32'd3);
    check_eq("ovr_data_stable", 32'(out_data), 32'h11);
    sync_cyc();
    repeat (37) sync_cyc();
    @(negedge clk);
    check_eq("hold_data_end", 32'(out_data), 32'h11);
    check_eq("hold_valid_end", 32'(out_valid), 32'd1);
    sync_cyc();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    rdy_mode = 1;
    wait_idle(20);
    check_queues();

    // Timeout: pulse exactly TIMEOUT+1 cycles after the last byte.
    send_byte(8'hA5, 0); send_byte(8'h02, 0);
    err_q.push_back(2'd0);
    send_byte(8'h11, 0);
    first = 0;
    busy_prev = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (frame_err) begin
        first = c;
        break;
      end
      busy_prev = busy;
    end
    check_eq("tmo_cycle", 32'(first), 32'(TIMEOUT + 1));
    check_eq("tmo_busy_drop", 32'(busy), 32'd0);
    check_eq("tmo_busy_before", 32'(busy_prev), 32'd1);
    sync_cyc();
    check_queues();

    // Reset mid-payload, then mid-drain, then a clean frame.
    send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    do_reset();
    rdy_mode = 0;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h44, 0); send_byte(8'h45, 0);
    @(negedge clk);
    check_eq("pre_rst_drain", 32'(out_valid), 32'd1);
    sync_cyc();
    do_reset();
    rdy_mode = 1;
    exp_q.push_back({1'b1, 8'h7F});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'h80, 0);
    wait_idle(20);
    check_queues();

    // Randomized frame stream against the frame-level model.
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      ng   = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, rgap());
      end
      send_byte(8'hA5, rgap());
      if (kind == 3) begin
        len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        err_q.push_back(2'd1);
        send_byte(8'(len), rgap());
      end else begin
        len = $urandom_range(1, MAX_LEN);
        sum = 8'(len);
        send_byte(8'(len), rgap());
        k = (kind == 4) ? $urandom_range(0, len) : len;
        for (int i = 0; i < k; i++) begin
          b = 8'($urandom);
          sum = sum + b;
          if (kind <= 1) exp_q.push_back({1'(i == len - 1), b});
          send_byte(b, rgap());
        end
        if (kind == 4) begin
          err_q.push_back(2'd0);
        end else if (kind == 2) begin
          err_q.push_back(2'd2);
          send_byte(sum + 8'($urandom_range(1, 255)), 0);
        end else begin
          send_byte(sum, 0);
        end
      end
      wait_idle(600);
      check_queues();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
